// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a synchronous single-port word memory.
// A request is captured in IDLE, held for LATENCY cycles, then answered until accepted.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    err_q, err_d;

    logic                    req_fire;
    logic                    resp_fire;
    logic                    req_err;
    logic                    commit;

    logic [31:0]             mem [Depth];
    logic [31:0]             rd_q;

    assign req_ready  = reset_n && (state_q == StIdle);
    assign req_fire   = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_fire  = resp_valid && resp_ready;

    // Out of range means any byte-address bit above the word index is set.
    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // The single memory access of a transaction happens on the WAIT->RESP edge.
    assign commit = (state_q == StWait) && (cnt_q == 3'd0);

    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? rd_q : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d = StWait;
                    cnt_d   = 3'(LATENCY - 1);
                    we_d    = req_we;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    err_d   = req_err;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            err_q   <= err_d;
        end
    end

    // No reset here so the array and read register map onto block RAM.
    always_ff @(posedge clk) begin
        if (commit && !err_q) begin
            if (we_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb_q[i]) begin
                        mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end else begin
                rd_q <= mem[idx_q];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_mem_responder;

    logic        clk;
    logic        reset_n;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid_1, req_ready_1, req_we_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic [3:0]  req_wstrb_1;
    logic        resp_valid_1, resp_ready_1, resp_err_1;
    logic [31:0] resp_rdata_1;

    int vectors;
    int miscompares;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid_1),
        .req_ready  (req_ready_1),
        .req_we     (req_we_1),
        .req_addr   (req_addr_1),
        .req_wdata  (req_wdata_1),
        .req_wstrb  (req_wstrb_1),
        .resp_valid (resp_valid_1),
        .resp_ready (resp_ready_1),
        .resp_rdata (resp_rdata_1),
        .resp_err   (resp_err_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (sel) begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d; req_wstrb_1 = s;
        end else begin
            req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        end
    endtask

    // Wait for resp_valid after the accept edge; returns cycles counted (bounded).
    task automatic wait_resp(input bit sel, output int lat);
        lat = 0;
        while (((sel ? resp_valid_1 : resp_valid) !== 1'b1) && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Called #1 after a posedge with the selected DUT idle and resp_ready=1.
    task automatic txn(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        int lat;
        check({tag, "/req_ready_idle"}, sel ? req_ready_1 : req_ready, 1'b1);
        drive(sel, 1'b1, we, a, d, s);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
        wait_resp(sel, lat);
        check({tag, "/latency"}, lat, sel ? 32'd1 : 32'd2);
        check({tag, "/rdata"}, sel ? resp_rdata_1 : resp_rdata, exp_rd);
        check({tag, "/err"}, sel ? resp_err_1 : resp_err, exp_err);
        check({tag, "/req_ready_resp"}, sel ? req_ready_1 : req_ready, 1'b0);
        @(posedge clk); #1;
        check({tag, "/resp_valid_after"}, sel ? resp_valid_1 : resp_valid, 1'b0);
        check({tag, "/req_ready_after"}, sel ? req_ready_1 : req_ready, 1'b1);
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        resp_ready  = 1'b1;
        resp_ready_1 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        #12;
        check("reset/resp_valid", resp_valid, 1'b0);
        check("reset/req_ready", req_ready, 1'b0);
        check("reset/rdata", resp_rdata, 32'd0);
        check("reset/err", resp_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic store then load
        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, "st10");
        txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10");

        // Byte strobes, then a zero-strobe store that must change nothing
        txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0, "st20_full");
        txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'd0, 1'b0, "st20_strb5");
        txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, "ld20_strb");
        txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, "st20_strb0");
        txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, "ld20_strb0");

        // Errors: misaligned load, out-of-range store leaves word 0 alone
        txn(1'b0, 1'b0, 32'h22, 32'd0, 4'h0, 32'd0, 1'b1, "ld22_misalign");
        txn(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, 32'd0, 1'b0, "st0");
        txn(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "st1000_range");
        txn(1'b0, 1'b0, 32'h0, 32'd0, 4'h0, 32'h12345678, 1'b0, "ld0_after_err");

        // Backpressure with a competing store presented during RESP
        resp_ready = 1'b0;
        check("bp/req_ready_idle", req_ready, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        wait_resp(1'b0, lat);
        check("bp/latency", lat, 32'd2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 4'hF);
            check("bp/resp_valid", resp_valid, 1'b1);
            check("bp/rdata", resp_rdata, 32'hDEADBEEF);
            check("bp/err", resp_err, 1'b0);
            check("bp/req_ready", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check("bp/still_valid", resp_valid, 1'b1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/resp_valid_after", resp_valid, 1'b0);
        txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "ld10_after_bp");

        // Reset during WAIT of a store abandons it
        txn(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, 32'd0, 1'b0, "st30_zero");
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check("rst_wait/in_wait", resp_valid, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_wait/resp_valid", resp_valid, 1'b0);
        check("rst_wait/req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        check("rst_wait/resp_valid_edge", resp_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'h30, 32'd0, 4'h0, 32'h0, 1'b0, "ld30_after_rst");

        // LATENCY=1 instance, back-to-back transactions
        txn(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0, "l1_st40");
        txn(1'b1, 1'b1, 32'h44, 32'h5A5A5A5A, 4'hF, 32'd0, 1'b0, "l1_st44");
        txn(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0, "l1_ld40");
        txn(1'b1, 1'b0, 32'h44, 32'd0, 4'h0, 32'h5A5A5A5A, 1'b0, "l1_ld44");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
